romram_seq_engine: RTL and testbench
====================================

Name: romram_seq_engine

Overview:
Clocked, parametrised ROM-to-RAM transfer engine. It holds a read-only table and a small scratch RAM, and runs one command per start pulse:
- ACCUM: sums a run of ROM words into one RAM word.
- COPY: copies a run of ROM words into consecutive RAM words.
After either mode, the final value is compared against a reference ROM word and reported with a done pulse. It replaces hand-timed #delay sequencing with an FSM usable inside synchronous datapaths.

Parameters:
DW, 16, data word width
ROM_AW, 4, ROM address width; ROM_DEPTH = 2**ROM_AW
RAM_AW, 2, RAM address width; RAM_DEPTH = 2**RAM_AW
CHECK_VAL, 16'h69, contents of the last ROM word; ROM[i] = i (truncated to DW) for i < ROM_DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command request, sampled only in IDLE
mode  in  1  0 = COPY, 1 = ACCUM
src_addr  in  ROM_AW  first ROM address
count  in  ROM_AW+1  number of ROM words to process (0 allowed)
dst_addr  in  RAM_AW  RAM destination (first destination in COPY)
ref_addr  in  ROM_AW  ROM address of the compare reference
rd_addr  in  RAM_AW  host read address
rd_data  out  DW  combinational RAM[rd_addr]
busy  out  1  high from the accepting edge until DONE exits
done  out  1  one-cycle completion pulse
result  out  DW  final value (sum, or last word copied)
match  out  1  result == ROM[ref_addr]
overflow  out  1  sticky carry-out of the ACCUM (see Optional Feature)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state = IDLE; busy, done, match, overflow = 0; result = 0; k = 0.
- RAM contents are zero at time 0 and are NOT cleared by reset.
- ROM and RAM reads are combinational. RAM writes are synchronous, one per cycle, FSM only.
- Command capture: the edge that samples start=1 in IDLE is edge 0. On that edge mode, src_addr, count, dst_addr and ref_addr are latched, and busy rises.
- start while busy is ignored. Inputs other than start are don't-care while busy.

FSM states:
- IDLE: wait for start.
- CLR: ACCUM writes RAM[dst]=0; COPY writes nothing. k=0. Next state is CMP if count==0, else STEP.
- STEP (one per word):
  - ACCUM: RAM[dst] <= RAM[dst] + ROM[(src+k) mod ROM_DEPTH], truncated to DW.
  - COPY: RAM[(dst+k) mod RAM_DEPTH] <= ROM[(src+k) mod ROM_DEPTH].
  - k++. Exit to CMP after the write with k == count-1.
- CMP:
  - result <= RAM[dst] in ACCUM, or the last word copied in COPY (0 if count==0).
  - match <= (that value == ROM[ref_addr]).
  - done <= 1.
- DONE: done <= 0, busy <= 0, return to IDLE.

Timing and boundaries:
- done is high in the cycle after edge count+2 for exactly one cycle; result and match are valid from that same edge.
- result, match and overflow hold until the next CMP or reset.
- ROM reads wrap modulo ROM_DEPTH. COPY destination wraps modulo RAM_DEPTH; if count > RAM_DEPTH, later words overwrite earlier ones.
- count == 0: ACCUM leaves RAM[dst] = 0 and result = 0; COPY writes nothing and result = 0.
- Reset mid-operation: FSM aborts to IDLE with outputs at reset values. RAM keeps any partial writes.
- A new start may be sampled on the edge after DONE exits (back-to-back commands allowed).

Optional Feature:
Macro: ROMRAM_OVF_DETECT_EN.
- Defined: ACCUM additions are done at DW+1 bits. overflow clears in CLR and is set sticky on any carry-out. result remains the DW-bit truncated sum.
- Undefined: overflow is tied to 0 and no extra adder bit is built.

Test Plan:
- Default parameters, ACCUM, src=0, count=15, dst=1, ref=15 -> RAM[1]=result=0x0069, match=1, done pulse one cycle after edge 17, busy low after edge 18.
- COPY, src=15, count=1, dst=3, ref=15 -> rd_addr=3 gives 0x0069, result=0x0069, match=1, other RAM words unchanged.
- ACCUM, src=14, count=3 (wrap) -> 14+0x69+0 = result 0x0077, match=0 with ref=15. Then count=0, ref=0 -> result=0, match=1, done one cycle after edge 2.
- COPY, src=4, count=6, dst=2 (RAM wrap) -> RAM[2..3,0..1] end as 8,9,6,7, result=9. A start pulse mid-run is ignored with no second done.
- Assert rst_n=0 asynchronously during STEP of a 15-word ACCUM -> busy, done, result, match drop immediately. A subsequent full command still gives 0x0069.
- With ROMRAM_OVF_DETECT_EN, DW=8, CHECK_VAL=8'hFF, ACCUM src=14, count=2 -> result=0x0D, overflow=1. Without the macro, overflow=0.

Source files
------------

// File: rtl/romram_seq_engine.sv
// romram_seq_engine: ROM-to-RAM accumulate/copy sequencer with a reference compare and a done pulse.
// Optional ROMRAM_OVF_DETECT_EN adds a sticky carry-out flag for ACCUM.
module romram_seq_engine #(
  parameter int DW = 16,
  parameter int ROM_AW = 4,
  parameter int RAM_AW = 2,
  parameter logic [DW-1:0] CHECK_VAL = 16'h69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ROM_AW-1:0] src_addr,
  input  logic [ROM_AW:0]   count,
  input  logic [RAM_AW-1:0] dst_addr,
  input  logic [ROM_AW-1:0] ref_addr,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     result,
  output logic              match,
  output logic              overflow
);
  typedef enum logic [2:0] {IDLE, CLR, STEP, CMP, DONE} state_t;
  state_t state, state_nxt;
  logic md;
  logic [ROM_AW-1:0] src, rf;
  logic [ROM_AW:0] cnt, k;
  logic [RAM_AW-1:0] dst, wr_addr, last_addr;
  logic [DW-1:0] ram [2**RAM_AW];
  logic [DW-1:0] rom_word, cmp_val;
  function automatic logic [DW-1:0] rom(input logic [ROM_AW-1:0] a);
    return &a ? CHECK_VAL : DW'(a);
  endfunction
  assign rom_word = rom(src + ROM_AW'(k));
  assign wr_addr = md ? dst : dst + RAM_AW'(k);
  // the final COPY write always lands at dst+count-1, even after wrapping
  assign last_addr = dst + RAM_AW'(cnt) - 1'b1;
  assign cmp_val = md ? ram[dst] : (cnt == '0 ? '0 : ram[last_addr]);
  assign rd_data = ram[rd_addr];
`ifdef ROMRAM_OVF_DETECT_EN
  logic [DW:0] sum;
  logic ovf;
  assign sum = {1'b0, ram[dst]} + {1'b0, rom_word};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == CLR) ovf <= 1'b0;
    else if (state == STEP && md && sum[DW]) ovf <= 1'b1;
  assign overflow = ovf;
`else
  logic [DW-1:0] sum;
  assign sum = ram[dst] + rom_word;
  assign overflow = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? CLR : IDLE;
      CLR: state_nxt = cnt == '0 ? CMP : STEP;
      STEP: state_nxt = k + 1'b1 == cnt ? CMP : STEP;
      CMP: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {md, src, cnt, dst, rf, k} <= '0;
      {busy, done, match} <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          {md, src, cnt, dst, rf} <= {mode, src_addr, count, dst_addr, ref_addr};
          busy <= 1'b1;
        end
        CLR: k <= '0;
        STEP: k <= k + 1'b1;
        CMP: begin
          result <= cmp_val;
          match <= cmp_val == rom(rf);
          done <= 1'b1;
        end
        DONE: {busy, done} <= '0;
        default: ;
      endcase
    end
  // RAM is deliberately outside reset so partial writes survive an abort
  always_ff @(posedge clk)
    if (state == CLR && md) ram[dst] <= '0;
    else if (state == STEP) ram[wr_addr] <= md ? sum[DW-1:0] : rom_word;
endmodule

// File: tb/tb_romram_seq_engine.sv
// tb_romram_seq_engine: randomized scoreboard bench for romram_seq_engine against a plain-arithmetic model.
module tb_romram_seq_engine;
  logic clk = 0, rst_n = 0, start = 0, start8 = 0, mode = 0;
  logic [3:0] src_addr = 0, ref_addr = 0;
  logic [4:0] count = 0;
  logic [1:0] dst_addr = 0, rd_addr = 0;
  logic [15:0] rd_data, result;
  logic busy, done, match, overflow;
  logic [7:0] rd8, res8;
  logic busy8, done8, match8, ovf8;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [15:0] res; logic m; int at;} exp_t;
  exp_t q[$];
  logic [15:0] mram [4];

  romram_seq_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src_addr(src_addr),
    .count(count), .dst_addr(dst_addr), .ref_addr(ref_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .result(result), .match(match),
    .overflow(overflow));

  romram_seq_engine #(.DW(8), .CHECK_VAL(8'hFF)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .src_addr(src_addr),
    .count(count), .dst_addr(dst_addr), .ref_addr(ref_addr), .rd_addr(rd_addr),
    .rd_data(rd8), .busy(busy8), .done(done8), .result(res8), .match(match8),
    .overflow(ovf8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rom(int a);
    return (a % 16) == 15 ? 'h69 : a % 16;
  endfunction

  function automatic exp_t model(bit md, int s, int c, int d, int r, int at);
    exp_t e;
    int acc = 0, last = 0;
    if (md) mram[d] = 0;
    for (int i = 0; i < c; i++) begin
      if (md) begin
        acc = (acc + rom(s + i)) % 65536;
        mram[d] = acc[15:0];
      end else begin
        last = rom(s + i);
        mram[(d + i) % 4] = last[15:0];
      end
    end
    e.res = md ? acc[15:0] : last[15:0];
    e.m = (int'(e.res) == rom(r));
    e.at = at;
    return e;
  endfunction

  task automatic issue(bit md, int s, int c, int d, int r);
    @(negedge clk);
    mode = md; src_addr = 4'(s); count = 5'(c); dst_addr = 2'(d); ref_addr = 4'(r); start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_rise", busy, 1);
    q.push_back(model(md, s, c, d, r, cyc + c + 2));
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_ram();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk($sformatf("ram%0d", a), rd_data, mram[a]);
    end
  endtask

  // monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("match", match, e.m);
          chk("done_cycle", cyc, e.at);
          chk("overflow", overflow, 0);
          @(negedge clk);
          chk("done_pulse", done, 0);
          chk("busy_fall", busy, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp8, ov8;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_result", result, 0); chk("rst_match", match, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(0, 0, 4, 0, 3); wait_done(); check_ram();
    issue(1, 0, 15, 1, 15); wait_done(); check_ram();
    issue(0, 15, 1, 3, 15); wait_done(); check_ram();
    issue(1, 14, 3, 2, 15); wait_done();
    issue(1, 5, 0, 2, 0); wait_done(); check_ram();
    issue(0, 4, 6, 2, 9);
    repeat (2) @(negedge clk);
    mode = 1; src_addr = 1; count = 3; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(); check_ram();
    // asynchronous abort after CLR plus five accumulate steps
    @(negedge clk);
    mode = 1; src_addr = 0; count = 15; dst_addr = 0; ref_addr = 15; start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_result", result, 0); chk("abort_match", match, 0);
    void'(model(1, 0, 5, 0, 15, 0));
    @(negedge clk);
    rst_n = 1;
    check_ram();
    issue(1, 0, 15, 0, 15); wait_done(); check_ram();
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 20)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      wait_done();
      if (i % 4 == 3) check_ram();
    end
    // narrow instance: 14 + 0xFF carries out of 8 bits
    @(negedge clk);
    mode = 1; src_addr = 14; count = 2; dst_addr = 0; ref_addr = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int n = 0; n < 20 && !done8; n++) @(negedge clk);
    exp8 = (14 + 'hFF) % 256;
`ifdef ROMRAM_OVF_DETECT_EN
    ov8 = (14 + 'hFF) > 255;
`else
    ov8 = 0;
`endif
    chk("done8_seen", done8, 1);
    chk("result8", res8, exp8);
    chk("match8", match8, 0);
    chk("overflow8", ovf8, ov8);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
